fp_operand_dispatch: RTL and testbench
======================================

# fp_operand_dispatch

Registered, parametrised operand dispatcher for the floating-point adder datapath. It accepts one operand pair (NA, NB) per cycle with a path-select code, typically the exponent-difference class. It steers the pair into one of N per-path FIFOs, and each path stage drains its FIFO through its own valid/ready handshake. Unselected paths hold their state rather than receiving undefined data, and illegal select codes are counted and dropped.

## Interface
- W, 37: operand width in bits (sign + exponent + extended mantissa).
- N, 3: number of downstream paths; N ≥ 2.
- SELW, 2: select width; 2^SELW ≥ N.
- DEPTH, 2: entries per path FIFO; power of two, ≥ 2.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and select are valid.
- in_ready  out  1  dispatcher accepts this cycle.
- in_na  in  W  operand A.
- in_nb  in  W  operand B.
- in_sel  in  SELW  destination path index.
- out_valid  out  N  bit k: path k head entry valid.
- out_ready  in  N  bit k: path k consumes head entry.
- out_na  out  N*W  path k operand A at [k*W +: W].
- out_nb  out  N*W  path k operand B at [k*W +: W].
- drop_pulse  out  1  one-cycle flag: an illegal-select transfer was dropped.
- drop_count  out  8  saturating count of dropped transfers.

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready is 1 if in_sel ≥ N. Otherwise it is !full[in_sel]. A same-cycle pop on the target path does not make room; there is no pop-through.
- Upstream holds in_na, in_nb and in_sel stable while in_valid && !in_ready.
- On accept with in_sel = k < N:
  - Write {in_na, in_nb} at path k's write pointer.
  - Advance the pointer, wrapping modulo DEPTH.
  - Increment path k's occupancy.
- On accept with in_sel ≥ N:
  - Nothing is stored.
  - drop_pulse = 1 next cycle.
  - drop_count increments and saturates at 255.
- Pop of path k occurs when out_valid[k] && out_ready[k]. The read pointer advances with wrap, and occupancy decrements.
- Simultaneous push and pop on the same path leaves occupancy unchanged; both pointers advance.
- out_valid[k] = (occupancy[k] != 0).
- out_na and out_nb for path k always show the entry at path k's read pointer.
  - When the path is empty, this is the stale last-written value, or zero after reset; never X.
- NA and NB always travel together. Path k's out_nb carries the in_nb accepted with that entry.
- Each path is strictly FIFO. There is no ordering guarantee across paths.
- Paths operate independently: a full or stalled path does not block transfers to other paths.

## Timing
- Reset (synchronous, while rst = 1 at a clk edge):
  - All pointers and occupancies = 0.
  - Storage is cleared to 0.
  - out_valid = 0, drop_pulse = 0, drop_count = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all queued entries. No pop is reported in the reset cycle.
- Latency: an entry accepted at edge t gives out_valid[k] = 1 after edge t, i.e. a one-cycle registered path with no combinational bypass.
- Throughput: one accept per cycle per dispatcher. With DEPTH ≥ 2 and out_ready[k] held high, path k sustains one transfer per cycle without in_ready dropping.
- Full: occupancy = DEPTH drives in_ready low only for in_sel = k. A pop at edge t re-enables accept in the cycle after t.
- Empty: a pop is ignored when out_valid[k] = 0, regardless of out_ready.
- drop_pulse is high for exactly one cycle per dropped transfer. It is high on back-to-back cycles for consecutive drops.
- Outputs depend only on registered state, except in_ready, which is combinational from in_sel and the full flags.

## Test plan
- Reset, then the checks:
  - Drive in_valid=1 with in_sel=1, NA=37'h0_1234_5678, NB=37'h1_0000_00FF.
    - Expect out_valid=3'b010 next cycle, path 1 out_na=37'h0_1234_5678 and out_nb=37'h1_0000_00FF.
    - Paths 0 and 2 read zero.
  - Fill path 0 with 2 entries while out_ready[0]=0.
    - Expect in_ready=0 for in_sel=0 and in_ready=1 for in_sel=2.
    - A transfer to path 2 completes. Raising out_ready[0] pops entries in order, and in_ready for path 0 returns one cycle after the first pop.
  - Send in_sel=3 three times back-to-back.
    - Expect drop_pulse high for 3 cycles, drop_count=3, out_valid unchanged.
    - After 300 illegal transfers, drop_count=255.
  - Stream 16 pairs to path 2 with out_ready[2]=1.
    - Expect in_ready to stay 1 and out_valid[2] to stay 1 from cycle 2.
    - Output data matches input order exactly, including across pointer wrap.
  - Assert rst for one cycle with 2 entries in path 0 and 1 entry in path 1.
    - Expect out_valid=0 and drop_count=0 next cycle, and the next accept writes to entry 0.

Source files
------------

// File: rtl/fp_operand_dispatch.sv
// Operand-pair dispatcher: steers {na, nb} into one of N per-path FIFOs by select
// code; illegal selects are dropped and counted.
module fp_operand_dispatch #(
  parameter int W     = 37,
  parameter int N     = 3,
  parameter int SELW  = 2,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_na,
  input  logic [W-1:0]      in_nb,
  input  logic [SELW-1:0]   in_sel,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [N*W-1:0]    out_na,
  output logic [N*W-1:0]    out_nb,
  output logic              drop_pulse,
  output logic [7:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_na [N][DEPTH];
  logic [W-1:0]  mem_nb [N][DEPTH];
  logic [AW-1:0] wptr   [N];
  logic [AW-1:0] rptr   [N];
  logic [CW-1:0] occ    [N];

  logic          sel_legal;
  logic          accept;
  logic [N-1:0]  full;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;

  // Ready looks only at the pre-edge full flag, so a same-cycle pop never makes room.
  always_comb begin
    sel_legal = 1'b0;
    in_ready  = 1'b1;
    full      = '0;
    pop       = '0;
    push      = '0;
    for (int k = 0; k < N; k++) begin
      full[k] = (occ[k] == CW'(DEPTH));
      pop[k]  = (occ[k] != '0) && out_ready[k];
      if (in_sel == SELW'(k)) begin
        sel_legal = 1'b1;
        in_ready  = !full[k];
      end
    end
    accept = in_valid && in_ready;
    for (int k = 0; k < N; k++) begin
      push[k] = accept && (in_sel == SELW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        occ[k]  <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_na[k][d] <= '0;
          mem_nb[k][d] <= '0;
        end
      end
      drop_pulse <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push[k]) begin
          mem_na[k][wptr[k]] <= in_na;
          mem_nb[k][wptr[k]] <= in_nb;
          wptr[k]            <= wptr[k] + 1'b1;
        end
        if (pop[k]) begin
          rptr[k] <= rptr[k] + 1'b1;
        end
        if (push[k] && !pop[k]) begin
          occ[k] <= occ[k] + 1'b1;
        end else if (pop[k] && !push[k]) begin
          occ[k] <= occ[k] - 1'b1;
        end
      end
      drop_pulse <= accept && !sel_legal;
      if (accept && !sel_legal && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_valid[k]       = (occ[k] != '0);
    assign out_na[k*W +: W]   = mem_na[k][rptr[k]];
    assign out_nb[k*W +: W]   = mem_nb[k][rptr[k]];
  end

endmodule

// File: tb/tb_fp_operand_dispatch.sv
// Self-checking bench for fp_operand_dispatch: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fp_operand_dispatch;

  localparam int W     = 37;
  localparam int N     = 3;
  localparam int SELW  = 2;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_na;
  logic [W-1:0]      in_nb;
  logic [SELW-1:0]   in_sel;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N*W-1:0]    out_na;
  logic [N*W-1:0]    out_nb;
  logic              drop_pulse;
  logic [7:0]        drop_count;

  fp_operand_dispatch #(.W(W), .N(N), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_na(in_na), .in_nb(in_nb), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_na(out_na), .out_nb(out_nb),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: one queue of operand pairs per path, plus the drop counter.
  logic [W-1:0] qa [N][$];
  logic [W-1:0] qb [N][$];
  int           m_drops;
  bit           m_drop_pulse;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit             v;
    logic [SELW-1:0] sel;
    logic [W-1:0]   na;
    logic [W-1:0]   nb;
    logic [N-1:0]   ordy;
    bit             exp_rdy;
    logic [N-1:0]   exp_ov;
    bit             exp_dp;
    logic [7:0]     exp_dc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready(input logic [SELW-1:0] s);
    if (int'(s) >= N) return 1'b1;
    return qa[s].size() < DEPTH;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("out_valid[%0d]", k), out_valid[k], qa[k].size() != 0);
      if (qa[k].size() != 0) begin
        chk($sformatf("out_na[%0d]", k), out_na[k*W +: W], qa[k][0]);
        chk($sformatf("out_nb[%0d]", k), out_nb[k*W +: W], qb[k][0]);
      end
    end
    chk("drop_pulse", drop_pulse, m_drop_pulse);
    chk("drop_count", drop_count, m_drops);
  endtask

  // One clock: drive, check in_ready, advance the model at the edge, check outputs.
  task automatic cycle(input bit v, input logic [SELW-1:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [N-1:0] ordy, output bit rdy_dut);
    bit rdy;
    bit acc;
    in_valid  = v;
    in_sel    = s;
    in_na     = a;
    in_nb     = b;
    out_ready = ordy;
    #1;
    rdy     = m_ready(s);
    rdy_dut = in_ready;
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (ordy[k] && qa[k].size() != 0) begin
        void'(qa[k].pop_front());
        void'(qb[k].pop_front());
      end
    end
    m_drop_pulse = acc && (int'(s) >= N);
    if (acc && int'(s) < N) begin
      qa[s].push_back(a);
      qb[s].push_back(b);
    end
    if (m_drop_pulse && m_drops < 255) m_drops++;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = '1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      qa[k].delete();
      qb[k].delete();
    end
    m_drops      = 0;
    m_drop_pulse = 1'b0;
    check_outputs();
    chk("reset_out_na", out_na, '0);
    chk("reset_out_nb", out_nb, '0);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    bit           r;
    bit           hv;
    logic [SELW-1:0] hs;
    logic [W-1:0] ha, hb;
    logic [63:0]  rnd;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_na = '0; in_nb = '0; out_ready = '0;
    m_drops = 0; m_drop_pulse = 1'b0;

    tbl[0]  = '{1'b1, 2'd1, 37'h0_1234_5678, 37'h1_0000_00FF, 3'b000, 1'b1, 3'b010, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 2'd0, 37'h0_0000_0A01, 37'h1_0000_0B01, 3'b000, 1'b1, 3'b011, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 2'd0, 37'h0_0000_0A02, 37'h1_0000_0B02, 3'b000, 1'b1, 3'b011, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 2'd0, 37'h0_0000_0A03, 37'h1_0000_0B03, 3'b000, 1'b0, 3'b011, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 2'd2, 37'h1_5555_AAAA, 37'h0_AAAA_5555, 3'b000, 1'b1, 3'b111, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 2'd0, 37'h0_0000_0A03, 37'h1_0000_0B03, 3'b001, 1'b0, 3'b111, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 2'd0, 37'h0_0000_0A03, 37'h1_0000_0B03, 3'b001, 1'b1, 3'b111, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 2'd0, 37'h0,           37'h0,           3'b001, 1'b1, 3'b110, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 2'd3, 37'h1_DEAD_0001, 37'h0_BEEF_0001, 3'b000, 1'b1, 3'b110, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 2'd3, 37'h1_DEAD_0002, 37'h0_BEEF_0002, 3'b000, 1'b1, 3'b110, 1'b1, 8'd2};
    tbl[10] = '{1'b1, 2'd3, 37'h1_DEAD_0003, 37'h0_BEEF_0003, 3'b000, 1'b1, 3'b110, 1'b1, 8'd3};
    tbl[11] = '{1'b0, 2'd0, 37'h0,           37'h0,           3'b000, 1'b1, 3'b110, 1'b0, 8'd3};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].sel, tbl[i].na, tbl[i].nb, tbl[i].ordy, r);
      chk($sformatf("tbl%0d_in_ready", i), r, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_drop_pulse", i), drop_pulse, tbl[i].exp_dp);
      chk($sformatf("tbl%0d_drop_count", i), drop_count, tbl[i].exp_dc);
      if (i == 0) begin
        chk("tbl0_path1_na", out_na[W +: W], 37'h0_1234_5678);
        chk("tbl0_path1_nb", out_nb[W +: W], 37'h1_0000_00FF);
        chk("tbl0_path0_zero", out_na[0 +: W], '0);
        chk("tbl0_path2_zero", out_nb[2*W +: W], '0);
      end
    end

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, W'(i), W'(i + 7), 3'b000, r);
    chk("drop_count_sat", drop_count, 8'd255);
    chk("drop_sat_out_valid", out_valid, 3'b110);

    // Drain, then stream 16 pairs through path 2 across pointer wrap
    cycle(1'b0, 2'd0, '0, '0, 3'b111, r);
    for (int j = 0; j < 16; j++) begin
      cycle(1'b1, 2'd2, W'(64'h1_0000_0100 + j), W'(64'h0_0F00_0000 + j * 3), 3'b100, r);
      chk($sformatf("stream%0d_in_ready", j), r, 1'b1);
      chk($sformatf("stream%0d_valid2", j), out_valid[2], 1'b1);
    end
    cycle(1'b0, 2'd0, '0, '0, 3'b100, r);
    chk("stream_drained", out_valid, 3'b000);

    // Reset with entries queued on paths 0 and 1
    do_reset();
    cycle(1'b1, 2'd0, 37'h0_0000_1111, 37'h0_0000_2222, 3'b000, r);
    cycle(1'b1, 2'd0, 37'h0_0000_3333, 37'h0_0000_4444, 3'b000, r);
    cycle(1'b1, 2'd1, 37'h0_0000_5555, 37'h0_0000_6666, 3'b000, r);
    cycle(1'b1, 2'd3, 37'h0, 37'h0, 3'b000, r);
    chk("prereset_out_valid", out_valid, 3'b011);
    do_reset();
    chk("midreset_out_valid", out_valid, 3'b000);
    chk("midreset_drop_count", drop_count, 8'd0);
    cycle(1'b1, 2'd0, 37'h1_7777_0000, 37'h0_0000_8888, 3'b000, r);
    chk("postreset_na0", out_na[0 +: W], 37'h1_7777_0000);
    chk("postreset_nb0", out_nb[0 +: W], 37'h0_0000_8888);

    // Randomized traffic; upstream holds a stalled transfer stable
    hv = 1'b0; hs = '0; ha = '0; hb = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
        hv = 1'b0;
      end
      if (!(hv && !m_ready(hs))) begin
        hv  = ($urandom_range(3) != 0);
        hs  = SELW'($urandom_range(3));
        rnd = {$urandom(), $urandom()};
        ha  = rnd[W-1:0];
        rnd = {$urandom(), $urandom()};
        hb  = rnd[W-1:0];
      end
      cycle(hv, hs, ha, hb, N'($urandom_range((1 << N) - 1)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
